// File: rtl/layer_seq_ctrl_if.sv
// Handshake bundle between the layer sequencer and its environment
// (host start/clear, UART wrapper, conv engine, maxpool engine).
interface layer_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             err_clr;
  logic             uart_rd_start;
  logic             uart_rd_done;
  logic             uart_wr_start;
  logic             uart_wr_done;
  logic             conv_start;
  logic             conv_done;
  logic             pool_start;
  logic             pool_done;
  logic [2:0]       group_idx;
  logic [CNT_W-1:0] layer_idx;
  logic             busy;
  logic             system_end;
  logic             error;
  logic [2:0]       err_phase;

  // environment side: issues commands and done pulses
  modport master (
    output start, err_clr, uart_rd_done, uart_wr_done, conv_done, pool_done,
    input  uart_rd_start, uart_wr_start, conv_start, pool_start,
           group_idx, layer_idx, busy, system_end, error, err_phase
  );

  // sequencer side
  modport slave (
    input  start, err_clr, uart_rd_done, uart_wr_done, conv_done, pool_done,
    output uart_rd_start, uart_wr_start, conv_start, pool_start,
           group_idx, layer_idx, busy, system_end, error, err_phase
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Top-level inference sequencer: UART read, up to GROUPS groups of
// (N convs + 1 maxpool), UART write-back. Per-phase watchdog with a
// sticky error state that only err_clr (or reset) leaves.
module layer_seq_ctrl #(
  parameter int                      GROUPS    = 4,
  parameter int                      CNT_W     = 4,
  parameter logic [GROUPS*CNT_W-1:0] LAYER_DEF = 16'h4444,
  parameter int                      TMO_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  layer_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CONV  = 3'd2,
    S_POOL  = 3'd3,
    S_WRITE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [2:0]       grp, grp_n;
  logic [CNT_W-1:0] lay, lay_n;
  logic [TMO_W-1:0] wd, wd_n, wd_inc;
  logic [2:0]       ephase, ephase_n;
  logic             rd_s, rd_n, wr_s, wr_n, cv_s, cv_n, pl_s, pl_n;
  logic             sys_end, end_n;
  logic             active, done_ok;
  logic [3:0]       nxt_grp;
  logic [7:0][CNT_W-1:0] cnt_tab;

  // Count table padded to 8 entries so the 3-bit group index always lands in range
  always_comb begin
    cnt_tab = '0;
    cnt_tab[GROUPS-1:0] = LAYER_DEF;
  end

  assign active  = (state == S_READ) || (state == S_CONV) ||
                   (state == S_POOL) || (state == S_WRITE);
  // A done is only honoured in its own state and not while its start is still high
  assign done_ok = ((state == S_READ)  && bus.uart_rd_done && !rd_s) ||
                   ((state == S_CONV)  && bus.conv_done    && !cv_s) ||
                   ((state == S_POOL)  && bus.pool_done    && !pl_s) ||
                   ((state == S_WRITE) && bus.uart_wr_done && !wr_s);
  assign wd_inc  = (&wd) ? wd : wd + TMO_W'(1);
  assign nxt_grp = {1'b0, grp} + 4'd1;

  // Next-state, index and start-pulse decode
  always_comb begin
    state_n  = state;
    grp_n    = grp;
    lay_n    = lay;
    ephase_n = ephase;
    wd_n     = active ? wd_inc : wd;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    cv_n     = 1'b0;
    pl_n     = 1'b0;
    end_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_READ;
          rd_n    = 1'b1;
        end
      end
      S_READ: begin
        if (done_ok) begin
          grp_n = '0;
          lay_n = '0;
          if (cnt_tab[0] != '0) begin
            state_n = S_CONV;
            cv_n    = 1'b1;
          end else begin
            state_n = S_WRITE;
            wr_n    = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (done_ok) begin
          if (({1'b0, lay} + (CNT_W+1)'(1)) < {1'b0, cnt_tab[grp]}) begin
            lay_n = lay + CNT_W'(1);
            cv_n  = 1'b1;
          end else begin
            state_n = S_POOL;
            pl_n    = 1'b1;
          end
        end
      end
      S_POOL: begin
        if (done_ok) begin
          // a zero count ends the group list even if later entries are nonzero
          if ((nxt_grp < 4'(GROUPS)) && (cnt_tab[nxt_grp[2:0]] != '0)) begin
            grp_n   = nxt_grp[2:0];
            lay_n   = '0;
            state_n = S_CONV;
            cv_n    = 1'b1;
          end else begin
            state_n = S_WRITE;
            wr_n    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (done_ok) begin
          state_n = S_IDLE;
          end_n   = 1'b1;
          grp_n   = '0;
          lay_n   = '0;
        end
      end
      S_ERR: begin
        if (bus.err_clr) begin
          state_n = S_IDLE;
          grp_n   = '0;
          lay_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // a done landing in the timeout cycle takes precedence over the error
    if (active && !done_ok && (&wd_inc)) begin
      state_n  = S_ERR;
      ephase_n = state;
    end
    if (rd_n || wr_n || cv_n || pl_n) wd_n = '0;
  end

  // State, indices, watchdog and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grp     <= '0;
      lay     <= '0;
      wd      <= '0;
      ephase  <= '0;
      rd_s    <= 1'b0;
      wr_s    <= 1'b0;
      cv_s    <= 1'b0;
      pl_s    <= 1'b0;
      sys_end <= 1'b0;
    end else begin
      state   <= state_n;
      grp     <= grp_n;
      lay     <= lay_n;
      wd      <= wd_n;
      ephase  <= ephase_n;
      rd_s    <= rd_n;
      wr_s    <= wr_n;
      cv_s    <= cv_n;
      pl_s    <= pl_n;
      sys_end <= end_n;
    end
  end

  assign bus.uart_rd_start = rd_s;
  assign bus.uart_wr_start = wr_s;
  assign bus.conv_start    = cv_s;
  assign bus.pool_start    = pl_s;
  assign bus.group_idx     = grp;
  assign bus.layer_idx     = lay;
  assign bus.busy          = (state != S_IDLE);
  assign bus.system_end    = sys_end;
  assign bus.error         = (state == S_ERR);
  assign bus.err_phase     = ephase;

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
- Parametrised top-level sequencer for the accelerator datapath.
- Flow: UART read of input/weights, then up to GROUPS layer groups, each group N convolutions followed by one maxpool, then UART write-back.
- Per-group conv counts come from a packed parameter. Adds a per-phase watchdog, sticky error state, and layer/group index outputs.
- Sits above the conv engine, maxpool engine and UART wrapper; drives them with single-cycle start pulses and consumes their done pulses.

Parameters:
- GROUPS, 4, maximum number of layer groups (1..8).
- CNT_W, 4, bit width of each per-group conv count.
- LAYER_DEF, 16'h4444, packed counts; group g count = LAYER_DEF[g*CNT_W +: CNT_W]; width GROUPS*CNT_W.
- TMO_W, 20, watchdog counter width; timeout fires at 2^TMO_W-1 cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin one inference run
- err_clr  in  1  pulse: leave ERR, return to IDLE
- uart_rd_start  out  1  pulse: request UART read
- uart_rd_done  in  1  pulse: UART read complete
- uart_wr_start  out  1  pulse: request UART write
- uart_wr_done  in  1  pulse: UART write complete
- conv_start  out  1  pulse: start one conv layer
- conv_done  in  1  pulse: conv layer complete
- pool_start  out  1  pulse: start maxpool
- pool_done  in  1  pulse: maxpool complete
- group_idx  out  3  current group index
- layer_idx  out  CNT_W  conv layer index within current group
- busy  out  1  high in any state except IDLE
- system_end  out  1  one-cycle pulse when a run completes
- error  out  1  high while in ERR
- err_phase  out  3  state encoding in which the timeout occurred

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state IDLE; all start pulses, system_end, error, busy at 0; group_idx, layer_idx, err_phase at 0; watchdog at 0.
- States and encodings: IDLE=0, READ=1, CONV=2, POOL=3, WRITE=4, ERR=5.
- Start pulses: every *_start is registered and asserted exactly one cycle, in the first cycle after entering the corresponding state or re-entering CONV for the next layer.
- Done pulses: accepted only in the matching state, and only from the cycle after its start pulse. Done in any other state or cycle is ignored.
- IDLE: on start go to READ; start while busy is ignored.
- READ: on uart_rd_done, check count(0). If nonzero, go to CONV with group 0, layer 0. If zero, go directly to WRITE.
- CONV: on conv_done, if layer_idx+1 < count(group_idx), increment layer_idx and issue a new conv_start next cycle while staying in CONV. Otherwise go to POOL.
- POOL: on pool_done, the next group = group_idx+1.
  - If next group < GROUPS and count(next) != 0, set group_idx to next, clear layer_idx, go to CONV.
  - Otherwise go to WRITE.
  - A zero count terminates the group list; later groups are never run.
- WRITE: on uart_wr_done, go to IDLE, pulse system_end for one cycle, clear group_idx and layer_idx.
- Watchdog:
  - Cleared on every start pulse; increments each cycle in READ, CONV, POOL, WRITE; saturates.
  - On reaching all-ones with no done that cycle: go to ERR, capture err_phase = state.
  - A done arriving in the same cycle as the timeout wins: no error.
- ERR: error=1; no start pulses; all dones ignored. err_clr returns to IDLE and clears indices (err_phase is kept). start is ignored in ERR.
- Reset priority: rst has priority over everything. Reset mid-run aborts immediately; no pulse is emitted in the reset cycle or the cycle after.
- Simultaneous events: start and err_clr together in IDLE → start wins. Any counts above 0 are valid up to 2^CNT_W-1.

Test Plan:
- Defaults (16'h4444, GROUPS=4), single start, each done returned 3 cycles after its start → 1 uart_rd_start, 16 conv_start, 4 pool_start (after conv 4,8,12,16), 1 uart_wr_start, system_end once; group_idx steps 0..3.
- LAYER_DEF=16'h0021 → conv,pool,conv,conv,pool,write. Group 2 count 0 ends the sequence; group_idx never reaches 2.
- LAYER_DEF=16'h0000 → READ then WRITE, zero conv_start/pool_start, system_end asserted.
- TMO_W=4, conv_done withheld → ERR after 15 CONV cycles, error=1, err_phase=2. err_clr → IDLE, error=0. New start runs normally.
- Spurious pool_done in CONV, conv_done in the same cycle as conv_start, start during CONV → all ignored; conv_start count unchanged.
- rst asserted in POOL → next cycle IDLE, busy=0, indices 0, no pulses. Subsequent start gives a full clean run.
